// File: rtl/iob_regfile_w_rn.sv
// Register file with one byte-strobed write port and N_READ read ports.
// Optional registered reads and write bypass. A background sequencer sweeps every entry back to RST_VAL.
module iob_regfile_w_rn #(
    parameter int unsigned       ADDR_W    = 3,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       N_READ    = 2,
    parameter int unsigned       RDATA_REG = 1,
    parameter int unsigned       BYPASS    = 1,
    parameter logic [DATA_W-1:0] RST_VAL   = '0
) (
    input  logic                       clk_i,
    input  logic                       arst_n_i,
    input  logic                       en_i,
    input  logic                       clr_i,
    output logic                       busy_o,
    input  logic                       we_i,
    output logic                       wready_o,
    input  logic [ADDR_W-1:0]          waddr_i,
    input  logic [DATA_W/8-1:0]        wstrb_i,
    input  logic [DATA_W-1:0]          wdata_i,
    input  logic [N_READ*ADDR_W-1:0]   raddr_i,
    output logic [N_READ*DATA_W-1:0]   rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned NB    = DATA_W / 8;

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   cnt_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                wr_acc_c;
    logic [DATA_W-1:0]   wr_word_c;
    logic [DATA_W-1:0]   rd_word_c [N_READ];

    assign busy_o   = (state_q == S_CLEAR);
    assign wready_o = ~busy_o;
    assign wr_acc_c = en_i & we_i & ~busy_o;

    // Merged word: strobed bytes from wdata_i, the rest from the current entry
    always_comb begin
        wr_word_c = mem_q[waddr_i];
        for (int unsigned b = 0; b < NB; b++) begin
            if (wstrb_i[b]) begin
                wr_word_c[8*b +: 8] = wdata_i[8*b +: 8];
            end
        end
    end

    // Clear sequencer: one entry per enabled cycle, leaves after the last entry
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else if (en_i) begin
            case (state_q)
                S_IDLE: begin
                    if (clr_i) begin
                        state_q <= S_CLEAR;
                        cnt_q   <= '0;
                    end
                end
                S_CLEAR: begin
                    cnt_q <= cnt_q + ADDR_W'(1);
                    if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Storage: writes only outside a sweep, so the two updates never collide
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RST_VAL;
            end
        end else begin
            if (wr_acc_c) begin
                mem_q[waddr_i] <= wr_word_c;
            end
            if (en_i && (state_q == S_CLEAR)) begin
                mem_q[cnt_q] <= RST_VAL;
            end
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < N_READ; k++) begin
            if ((BYPASS != 0) && wr_acc_c && (waddr_i == raddr_i[k*ADDR_W +: ADDR_W])) begin
                rd_word_c[k] = wr_word_c;
            end else begin
                rd_word_c[k] = mem_q[raddr_i[k*ADDR_W +: ADDR_W]];
            end
        end
    end

    generate
        if (RDATA_REG != 0) begin : g_rd_reg
            logic [N_READ*DATA_W-1:0] rdata_q;

            always_ff @(posedge clk_i or negedge arst_n_i) begin
                if (!arst_n_i) begin
                    rdata_q <= '0;
                end else if (en_i) begin
                    for (int unsigned k = 0; k < N_READ; k++) begin
                        rdata_q[k*DATA_W +: DATA_W] <= rd_word_c[k];
                    end
                end
            end

            assign rdata_o = rdata_q;
        end else begin : g_rd_comb
            always_comb begin
                rdata_o = '0;
                for (int unsigned k = 0; k < N_READ; k++) begin
                    rdata_o[k*DATA_W +: DATA_W] = rd_word_c[k];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_iob_regfile_w_rn.sv
// Scoreboard bench for iob_regfile_w_rn: a bypass and a non-bypass instance share stimulus.
// An array-based reference model fills the expectation queue.
module tb_iob_regfile_w_rn;

    localparam logic [15:0] RST = 16'hA5A5;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        en, clr, we;
    logic [2:0]  waddr;
    logic [1:0]  wstrb;
    logic [15:0] wdata;
    logic [5:0]  raddr;
    logic        busy, wready, busy_nb, wready_nb;
    logic [31:0] rdata, rdata_nb;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        busy;
        logic [15:0] r0, r1, n0, n1;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] mem_m [8];
    bit          busy_m;
    int          cnt_m;
    logic [15:0] er [2];
    logic [15:0] en_m [2];

    always #5 clk = ~clk;

    iob_regfile_w_rn #(.ADDR_W(3), .DATA_W(16), .N_READ(2), .RDATA_REG(1), .BYPASS(1),
                       .RST_VAL(RST)) u_dut (
        .clk_i(clk), .arst_n_i(arst_n), .en_i(en), .clr_i(clr), .busy_o(busy),
        .we_i(we), .wready_o(wready), .waddr_i(waddr), .wstrb_i(wstrb), .wdata_i(wdata),
        .raddr_i(raddr), .rdata_o(rdata)
    );

    iob_regfile_w_rn #(.ADDR_W(3), .DATA_W(16), .N_READ(2), .RDATA_REG(1), .BYPASS(0),
                       .RST_VAL(RST)) u_dut_nb (
        .clk_i(clk), .arst_n_i(arst_n), .en_i(en), .clr_i(clr), .busy_o(busy_nb),
        .we_i(we), .wready_o(wready_nb), .waddr_i(waddr), .wstrb_i(wstrb), .wdata_i(wdata),
        .raddr_i(raddr), .rdata_o(rdata_nb)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mem_m[i] = RST;
        busy_m = 0;
        cnt_m  = 0;
        for (int k = 0; k < 2; k++) begin
            er[k]   = '0;
            en_m[k] = '0;
        end
    endtask

    // One cycle of stimulus; the model predicts the state seen right after the next edge
    task automatic drive(input bit e, input bit c, input bit w, input int wa,
                         input logic [1:0] st, input logic [15:0] wd, input int a0, input int a1);
        logic [15:0] merged;
        bit          wacc;
        int          ra [2];
        @(negedge clk);
        en = e; clr = c; we = w;
        waddr = 3'(wa); wstrb = st; wdata = wd;
        raddr = {3'(a1), 3'(a0)};
        ra[0] = a0;
        ra[1] = a1;
        merged = mem_m[wa];
        if (st[0]) merged[7:0]  = wd[7:0];
        if (st[1]) merged[15:8] = wd[15:8];
        wacc = e && w && !busy_m;
        if (e) begin
            for (int k = 0; k < 2; k++) begin
                er[k]   = (wacc && wa == ra[k]) ? merged : mem_m[ra[k]];
                en_m[k] = mem_m[ra[k]];
            end
        end
        if (wacc) mem_m[wa] = merged;
        if (e) begin
            if (busy_m) begin
                mem_m[cnt_m] = RST;
                cnt_m++;
                if (cnt_m == 8) busy_m = 0;
            end else if (c) begin
                busy_m = 1;
                cnt_m  = 0;
            end
        end
        sb_q.push_back('{busy: busy_m, r0: er[0], r1: er[1], n0: en_m[0], n1: en_m[1]});
    endtask

    task automatic rd_check(input int a, input logic [15:0] exp);
        drive(1, 0, 0, 0, 2'b00, 16'h0, a, 7 - a);
        @(posedge clk);
        #2;
        chk("direct_rd", {16'h0, rdata[15:0]}, {16'h0, exp});
    endtask

    // Monitor: registered outputs settle after every edge, one expectation per edge
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("busy",      {31'h0, busy},      {31'h0, e.busy});
                chk("wready",    {31'h0, wready},    {31'h0, ~e.busy});
                chk("busy_nb",   {31'h0, busy_nb},   {31'h0, e.busy});
                chk("rdata",     rdata,              {e.r1, e.r0});
                chk("rdata_nb",  rdata_nb,           {e.n1, e.n0});
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : main
        int nbusy;
        arst_n = 1'b0;
        en = 0; clr = 0; we = 0; waddr = '0; wstrb = '0; wdata = '0; raddr = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy",   {31'h0, busy},   32'h0);
        chk("rst_wready", {31'h0, wready}, 32'h1);
        chk("rst_rdata",  rdata,           32'h0);
        @(negedge clk);
        arst_n = 1'b1;

        // Reset contents on both ports
        for (int i = 0; i < 8; i++) drive(1, 0, 0, 0, 2'b00, 16'h0, i, 7 - i);

        // Partial byte write
        drive(1, 0, 1, 3, 2'b11, 16'h1234, 0, 0);
        drive(1, 0, 1, 3, 2'b01, 16'hFF00, 0, 0);
        rd_check(3, 16'h1200);

        // Same-cycle write/read: bypass vs. no bypass
        drive(1, 0, 1, 5, 2'b11, 16'hBEEF, 5, 4);
        @(posedge clk);
        #2;
        chk("byp_rd0",  {16'h0, rdata[15:0]},     {16'h0, 16'hBEEF});
        chk("byp_rd1",  {16'h0, rdata[31:16]},    {16'h0, RST});
        chk("nbyp_rd0", {16'h0, rdata_nb[15:0]},  {16'h0, RST});
        drive(1, 0, 0, 0, 2'b00, 16'h0, 5, 5);
        @(posedge clk);
        #2;
        chk("nbyp_rd0_next", {16'h0, rdata_nb[15:0]}, {16'h0, 16'hBEEF});

        // Fill, sweep with writes attempted during the sweep
        for (int i = 0; i < 8; i++) drive(1, 0, 1, i, 2'b11, 16'(i), i, i);
        nbusy = 0;
        for (int j = 0; j < 12; j++) begin
            drive(1, j == 0, (j >= 1 && j <= 8), j & 7, 2'b11, 16'h5A00 + 16'(j), j & 7, 7 - (j & 7));
            @(posedge clk);
            #2;
            if (busy) nbusy++;
        end
        chk("sweep_cycles", 32'(nbusy), 32'd8);
        for (int i = 0; i < 8; i++) rd_check(i, RST);

        // Enable held low mid-sweep
        for (int i = 0; i < 8; i++) drive(1, 0, 1, i, 2'b11, 16'h0100 + 16'(i), i, i);
        nbusy = 0;
        for (int j = 0; j < 14; j++) begin
            drive(!(j >= 3 && j <= 5), j == 0, 0, 0, 2'b00, 16'h0, j & 7, 0);
            @(posedge clk);
            #2;
            if (busy) nbusy++;
        end
        chk("frozen_sweep_cycles", 32'(nbusy), 32'd11);
        for (int i = 0; i < 8; i += 3) rd_check(i, RST);

        // Async reset mid-sweep
        for (int i = 0; i < 4; i++) drive(1, 0, 1, i, 2'b11, 16'h7700 + 16'(i), i, i);
        drive(1, 1, 0, 0, 2'b00, 16'h0, 0, 0);
        for (int j = 0; j < 3; j++) drive(1, 0, 0, 0, 2'b00, 16'h0, j, j);
        @(negedge clk);
        arst_n = 1'b0;
        #1;
        chk("arst_busy",  {31'h0, busy}, 32'h0);
        chk("arst_rdata", rdata,         32'h0);
        model_reset();
        @(negedge clk);
        arst_n = 1'b1;
        for (int i = 0; i < 8; i++) rd_check(i, RST);

        // Random traffic
        repeat (400) begin
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0, $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, 7)), 2'($urandom), 16'($urandom),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        end

        @(posedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
